// File: rtl/input_gpio_loader_if.sv
// ---------------------------------------------------------------------------
// input_gpio_loader_if
// Groups the external GPIO pixel handshake and the image-RAM write bus used
// by input_gpio_loader.
//
// Signals:
//   strobe_in  external request, asynchronous to the loader clock
//   data_in    external pixel, held by the master until it sees ack_out
//   ack_out    handshake acknowledge back to the master
//   wr_en      RAM write enable, one cycle per pixel
//   wr_addr    RAM write address
//   wr_data    RAM write data
//
// Modports:
//   master  the side that drives strobe/data and watches ack and the RAM bus
//   slave   the loader itself
// ---------------------------------------------------------------------------
interface input_gpio_loader_if #(
    parameter int ADDR_W = 18,
    parameter int DATA_W = 8
);
    logic              strobe_in;
    logic [DATA_W-1:0] data_in;
    logic              ack_out;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;

    modport master (
        output strobe_in,
        output data_in,
        input  ack_out,
        input  wr_en,
        input  wr_addr,
        input  wr_data
    );

    modport slave (
        input  strobe_in,
        input  data_in,
        output ack_out,
        output wr_en,
        output wr_addr,
        output wr_data
    );
endinterface

// File: rtl/input_gpio_loader.sv
// ---------------------------------------------------------------------------
// input_gpio_loader
// Receives the source image one pixel at a time over a 4-phase strobe/ack
// GPIO handshake and writes it into image RAM at addresses 0..IMG_PIXELS-1.
// Raises done once the full image is in RAM.
//
// Ports:
//   clk       system clock
//   rst       synchronous, active-high reset
//   enable    load session active; low aborts back to IDLE
//   bus       input_gpio_loader_if.slave (strobe/data/ack + RAM write bus)
//   busy      high while a load is in progress (WAIT_REQ/WRITE/WAIT_REL)
//   done      whole image loaded
//   checksum  16-bit running sum of written pixels
//
// Optional feature macro: LOADER_CHECKSUM_EN
//   defined     -> checksum is a modulo-2^16 sum of every written pixel,
//                  cleared on reset and on IDLE entry
//   not defined -> no accumulator, checksum tied to 0
// ---------------------------------------------------------------------------
module input_gpio_loader #(
    parameter int IMG_PIXELS = 160000,
    parameter int ADDR_W     = 18,
    parameter int DATA_W     = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input_gpio_loader_if.slave    bus,
    output logic                  busy,
    output logic                  done,
    output logic [15:0]           checksum
);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_REQ,
        WRITE,
        WAIT_REL,
        DONE
    } state_e;

    localparam logic [ADDR_W-1:0] LAST_COUNT = ADDR_W'(IMG_PIXELS);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   count_q, count_d;
    logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0]   wr_data_q, wr_data_d;
    logic                sync1_q, sync1_d;
    logic                strobe_s_q, strobe_s_d;

    // State and datapath registers. Reset puts every flop, including the
    // two-stage strobe synchronizer, back to zero / IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            count_q    <= '0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            sync1_q    <= 1'b0;
            strobe_s_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            sync1_q    <= sync1_d;
            strobe_s_q <= strobe_s_d;
        end
    end

    // Next-state logic. Dropping enable aborts from any state. WAIT_REL is
    // only left once the synchronized strobe is low, which is what limits a
    // long strobe pulse to a single write. The counter has already been
    // bumped by the time WAIT_REL is evaluated, so comparing it against
    // IMG_PIXELS tells whether the last pixel just went in.
    always_comb begin
        state_d = state_q;
        if (!enable) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE:     state_d = WAIT_REQ;
                WAIT_REQ: if (strobe_s_q) state_d = WRITE;
                WRITE:    state_d = WAIT_REL;
                WAIT_REL: begin
                    if (!strobe_s_q) begin
                        state_d = (count_q == LAST_COUNT) ? DONE : WAIT_REQ;
                    end
                end
                DONE:     state_d = DONE;
                default:  state_d = IDLE;
            endcase
        end
    end

    // Datapath next values. data_in is captured only on the WAIT_REQ->WRITE
    // transition, i.e. while the synchronized strobe is high, so the
    // master's hold guarantee makes the capture safe. The counter clears
    // whenever we head to IDLE and saturates at IMG_PIXELS.
    always_comb begin
        sync1_d    = bus.strobe_in;
        strobe_s_d = sync1_q;
        count_d    = count_q;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;

        if (state_q == WAIT_REQ && state_d == WRITE) begin
            wr_addr_d = count_q;
            wr_data_d = bus.data_in;
        end

        if (state_d == IDLE) begin
            count_d = '0;
        end else if (state_q == WRITE && count_q != LAST_COUNT) begin
            count_d = count_q + 1'b1;
        end
    end

    // Moore outputs decoded from the current state. wr_addr/wr_data simply
    // hold their last value between writes; wr_en is the only qualifier.
    always_comb begin
        bus.wr_en   = (state_q == WRITE);
        bus.ack_out = (state_q == WRITE) || (state_q == WAIT_REL);
        busy        = (state_q == WAIT_REQ) || (state_q == WRITE) ||
                      (state_q == WAIT_REL);
        done        = (state_q == DONE);
        bus.wr_addr = wr_addr_q;
        bus.wr_data = wr_data_q;
    end

`ifdef LOADER_CHECKSUM_EN
    logic [15:0] acc_q, acc_d;

    // Pixel checksum: adds the pixel being written during each WRITE cycle.
    // Cleared whenever the FSM is heading to IDLE so each session starts
    // from zero; it is frozen in DONE since no WRITE cycles occur there.
    always_comb begin
        acc_d = acc_q;
        if (state_d == IDLE) begin
            acc_d = '0;
        end else if (state_q == WRITE) begin
            acc_d = acc_q + 16'(wr_data_q);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign checksum = acc_q;
`else
    assign checksum = 16'h0000;
`endif

endmodule
